// File: rtl/des_pkg.sv
// Shared DES S-box stage definitions: fixed widths, FSM state encoding and the eight S-box tables.
// Each table row is a 64-bit word of sixteen 4-bit entries, column 0 in the top nibble.
package des_pkg;

    localparam int unsigned BlockW = 48;
    localparam int unsigned OutW   = 32;
    localparam int unsigned ChunkW = 6;
    localparam int unsigned NibW   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Indexed by {box[2:0], row[1:0]}; box 0 is S1.
    localparam logic [63:0] SboxRows [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

endpackage

// File: rtl/des_sbox_table.sv
// Combinational DES S-box lookup: box index plus 6-bit chunk b1..b6 (b1 in bit 5) gives 4 bits.
module des_sbox_table
    import des_pkg::*;
(
    input  logic [2:0]        box_i,
    input  logic [ChunkW-1:0] chunk_i,
    output logic [NibW-1:0]   val_o
);

    logic [63:0] row_word;
    logic [3:0]  col;

    always_comb begin
        row_word = SboxRows[{box_i, chunk_i[5], chunk_i[0]}];
        col      = chunk_i[4:1];
        // Column c sits at bits 4*(15-c) +: 4.
        val_o    = row_word[{~col, 2'b00} +: NibW];
    end

endmodule

// File: rtl/des_sbox_stage.sv
// DES S-box substitution stage with valid/ready on both sides. Default: one shared table, one box
// per clock. Define DES_SBOX_PARALLEL_EN for eight tables and a single-cycle 1-deep output register.
module des_sbox_stage
    import des_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BlockW-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OutW-1:0]   Y
);

    // Bit BlockW-1 of B and bit OutW-1 of Y carry DES bit 1.
`ifdef DES_SBOX_PARALLEL_EN

    logic            valid_q;
    logic [OutW-1:0] y_q;
    logic [OutW-1:0] sbox_y;

    for (genvar g = 0; g < 8; g++) begin : g_box
        des_sbox_table u_table (
            .box_i   (3'(g)),
            .chunk_i (B[BlockW-1-ChunkW*g -: ChunkW]),
            .val_o   (sbox_y[OutW-1-NibW*g -: NibW])
        );
    end

    always_comb in_ready = !rst && (!valid_q || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            y_q     <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            y_q     <= sbox_y;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign Y         = y_q;

`else

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [BlockW-1:0]   b_q, b_d;
    logic [OutW-1:0]     y_q, y_d;
    logic [ChunkW-1:0]   chunk;
    logic [NibW-1:0]     sval;

    always_comb begin
        chunk = '0;
        for (int i = 0; i < 8; i++) begin
            if (cnt_q == 3'(i)) chunk = b_q[BlockW-1-ChunkW*i -: ChunkW];
        end
    end

    des_sbox_table u_table (
        .box_i   (cnt_q),
        .chunk_i (chunk),
        .val_o   (sval)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        b_d       = b_q;
        y_d       = y_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    b_d     = B;
                    cnt_d   = 3'd0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                for (int i = 0; i < 8; i++) begin
                    if (cnt_q == 3'(i)) y_d[OutW-1-NibW*i -: NibW] = sval;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        b_d     = B;
                        cnt_d   = 3'd0;
                        state_d = StBusy;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst) in_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            b_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            y_q     <= y_d;
        end
    end

    assign Y = y_q;

`endif

endmodule

// File: tb/tb_des_sbox_stage.sv
// Scoreboard bench for des_sbox_stage: directed DES vectors with hand-computed S-box outputs.
module tb_des_sbox_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y;

    always #5 clk = ~clk;

    des_sbox_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y)
    );

`ifdef DES_SBOX_PARALLEL_EN
    // Result is registered on the accept edge itself.
    localparam int Lat = 0;
`else
    localparam int Lat = 8;
`endif

    typedef struct {
        logic [31:0] y;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors;
    int          checks;
    int          cyc;
    int          accepted;
    int          retired;
    int          dropped;
    bit          rand_ready;
    bit          fresh;
    bit          hold;
    logic [31:0] hold_y;
    logic [47:0] vb [9];
    logic [31:0] vy [9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Called at posedge+#1; holds B/in_valid until accepted, then scrambles B.
    task automatic send(input logic [47:0] b, input logic [31:0] y, input int gap);
        exp_t e;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        B        = b;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.y   = y;
                e.acc = cyc + 1;
                exp_q.push_back(e);
                accepted++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                B        = 48'hDEADBEEFCAFE;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready never rose for B=%0h", b);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 600 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on each output transfer, checks latency and stall stability.
    initial begin
        fresh = 1'b1;
        hold  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fresh = 1'b1;
                hold  = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_out_valid", 64'(out_valid), 64'd1);
                    chk("hold_y", 64'(Y), 64'(hold_y));
                end
                hold = 1'b0;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        if (fresh) begin
                            chk("latency", 64'(cyc - exp_q[0].acc), 64'(Lat));
                            fresh = 1'b0;
                        end
                        if (out_ready) begin
                            chk("y", 64'(Y), 64'(exp_q[0].y));
                            void'(exp_q.pop_front());
                            retired++;
                            fresh = 1'b1;
                        end else begin
                            hold   = 1'b1;
                            hold_y = Y;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vb[0] = 48'h000000000000; vy[0] = 32'hEFA72C4D;
        vb[1] = 48'hFFFFFFFFFFFF; vy[1] = 32'hD9CE3DCB;
        vb[2] = 48'h6C0000000000; vy[2] = 32'h5FA72C4D;
        vb[3] = 48'h861861861861; vy[3] = 32'hFD13B462;
        vb[4] = 48'h79E79E79E79E; vy[4] = 32'h7A8F9B17;
        vb[5] = 48'h082082082082; vy[5] = 32'h410DC1B2;
        vb[6] = 48'h555555555555; vy[6] = 32'hC152FD56;
        vb[7] = 48'hAAAAAAAAAAAA; vy[7] = 32'h64FBD83C;
        vb[8] = 48'h03F85E095A9B; vy[8] = 32'hE91FCD3E;

        errors = 0; checks = 0; cyc = 0; accepted = 0; retired = 0; dropped = 0;
        rand_ready = 1'b0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; B = '0;

        // Reset state, with in_ready forced low during reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(Y), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // Continuous flow: back-to-back handoff through DONE.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send(vb[i], vy[i], 0);
        drain();

        // Backpressure for 20 clocks, then same-edge handoff.
        out_ready = 1'b0;
        send(vb[7], vy[7], 0);
        for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
        send(vb[6], vy[6], 0);
        drain();

        // Reset mid-BUSY at cnt=4; the partial result is discarded.
        send(vb[6], vy[6], 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst     = 1'b1;
        dropped = dropped + exp_q.size();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_y", 64'(Y), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(vb[8], vy[8], 0);
        send(vb[3], vy[3], 0);
        drain();

        // Random handshake stream of 16 directed vectors.
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(vb[(i * 5) % 9], vy[(i * 5) % 9], int'($urandom_range(0, 3)));
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        chk("retired_count", 64'(retired), 64'(accepted - dropped));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
